sw_ctrl: RTL
============

SW_CTRL -- requirements
Module: sw_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_MS, default 20, the number of consecutive stable 1 ms cycles needed to accept a button level (range 2..63).
REQ-002 SHALL have parameter CLEAR_MS, default 2, the number of cycles Reset_S is held high in CLEAR (range 1..15).
REQ-003 SHALL have port Clock_1MSec, input, 1 bit: the 1 ms system clock, rising-edge, the only clock.
REQ-004 SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port Btn_StartStop, input, 1 bit: raw start/stop pushbutton, active-high, asynchronous and bouncing.
REQ-006 SHALL have port Btn_Reset, input, 1 bit: raw clear pushbutton, active-high, asynchronous and bouncing.
REQ-007 SHALL have port Control, input, 1 bit: mode select; 0 selects stopwatch, 1 selects clock.
REQ-008 SHALL have ports Start_S, Stop_S and Reset_S, each an output of 1 bit: level commands to the downstream stopwatch counter.
REQ-009 SHALL have port State_S, output, 2 bits: current FSM state, for the display and LEDs.

Function
REQ-010 SHALL pass each Btn_* input through a 2-flop synchronizer before any other use.
REQ-011 SHALL update a button's debounced level only after the synchronized input differs from it for DEBOUNCE_MS consecutive cycles; any single-cycle agreement restarts that button's counter at 0.
REQ-012 SHALL assert a press event for exactly 1 cycle on each 0->1 transition of a debounced level; releases SHALL produce no event.
REQ-013 SHALL give a total latency of DEBOUNCE_MS+3 cycles from a clean raw rising edge to the state change.
REQ-014 SHALL implement these FSM states and encodings: IDLE=00, RUN=01, PAUSED=10, CLEAR=11.
REQ-015 SHALL drive outputs by state as follows: IDLE gives Start_S=0, Stop_S=0, Reset_S=0; RUN gives 1,0,0; PAUSED gives 0,1,0; CLEAR gives 0,0,1.
REQ-016 SHALL transition IDLE to RUN on a StartStop press; a Reset press in IDLE SHALL be ignored.
REQ-017 SHALL transition RUN to PAUSED on a StartStop press; a Reset press in RUN SHALL be ignored.
REQ-018 SHALL transition PAUSED to RUN on a StartStop press and PAUSED to CLEAR on a Reset press; if both are pressed in the same cycle, Reset SHALL win.
REQ-019 SHALL remain in CLEAR for exactly CLEAR_MS cycles and then enter IDLE; any press during CLEAR SHALL be discarded.
REQ-020 SHALL, while Control=1, hold the FSM state and outputs and discard press events; debouncers SHALL keep running.
REQ-021 SHALL drive all outputs from registers, with no combinational path from any input to any output.

Reset
REQ-022 SHALL, on Reset=0, asynchronously clear the synchronizers, debounced levels, counters and event flags, set the FSM to IDLE, and drive Start_S=0, Stop_S=0, Reset_S=0, State_S=00.
REQ-023 SHALL, on reset assertion mid-debounce or mid-CLEAR, abort the operation; after release, a button still held SHALL be re-debounced and yield one press event.

Configuration
REQ-024 SHALL, when SW_CTRL_LAP_EN is defined, add input Btn_Lap (1 bit, raw) and output Lap_S (1 bit), debounced the same way as the other buttons.
REQ-025 SHALL, with SW_CTRL_LAP_EN defined, toggle Lap_S on each Lap press while in RUN or PAUSED, and clear Lap_S on entry to CLEAR or IDLE and on reset.
REQ-026 SHALL, when SW_CTRL_LAP_EN is undefined, omit the Btn_Lap and Lap_S ports and their logic entirely.

Structure
REQ-027 SHALL place the state encodings (IDLE, RUN, PAUSED, CLEAR) and the default DEBOUNCE_MS and CLEAR_MS constants in the shared package sw_pkg.
REQ-028 SHALL implement synchronizer, debounce and edge detect in one sub-module, sw_debounce (parameter DEBOUNCE_MS; ports Clock_1MSec, Reset, raw, level, press), instantiated once per button.

Verification
REQ-029 SHALL verify clean press: with DEBOUNCE_MS=20, Btn_StartStop high for 30 cycles from IDLE -> State_S=01 and Start_S=1 exactly 23 cycles after the rising edge.
REQ-030 SHALL verify bounce rejection: Btn_StartStop toggling every 5 cycles for 100 cycles, then low -> no state change, Start_S stays 0.
REQ-031 SHALL verify the full cycle: StartStop, StartStop, Reset presses -> the state sequence IDLE->RUN->PAUSED->CLEAR, then Reset_S=1 for exactly 2 cycles, then IDLE with all outputs 0.
REQ-032 SHALL verify simultaneous presses: in PAUSED, both buttons' debounced edges in the same cycle -> CLEAR, not RUN; in RUN, Reset press alone -> stays RUN.
REQ-033 SHALL verify mode lock: Control=1 in RUN with a StartStop press -> stays RUN; Control back to 0 -> no delayed transition.
REQ-034 SHALL verify reset mid-CLEAR: Reset=0 pulsed in CLEAR's first cycle -> outputs 0 and State_S=00 immediately, with no clock edge required.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared FSM encodings and default timing constants for the stopwatch button controller.
package sw_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      PAUSED = 2'b10,
      CLEAR  = 2'b11
   } sw_state_e;

   localparam int DEBOUNCE_MS_DEF = 20;
   localparam int CLEAR_MS_DEF    = 2;
   localparam int DB_CNT_W        = 6;
   localparam int CLR_CNT_W       = 4;

endpackage

// File: rtl/sw_debounce.sv
// Per-button 2-flop synchronizer, counter debouncer and registered rising-edge press event.
module sw_debounce
   import sw_pkg::*;
#(
   parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF
) (
   input  logic Clock_1MSec,
   input  logic Reset,
   input  logic raw,
   output logic level,
   output logic press
);

   logic                sync_p0;
   logic                sync_p1;
   logic [DB_CNT_W-1:0] cnt;

   always_ff @(posedge Clock_1MSec or negedge Reset) begin
      if (!Reset) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         cnt     <= '0;
         level   <= 1'b0;
         press   <= 1'b0;
      end else begin
         sync_p0 <= raw;
         sync_p1 <= sync_p0;
         press   <= 1'b0;
         // Any agreement with the accepted level restarts the stability count.
         if (sync_p1 == level) begin
            cnt <= '0;
         end else if (cnt == DB_CNT_W'(DEBOUNCE_MS - 1)) begin
            cnt   <= '0;
            level <= sync_p1;
            press <= sync_p1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sw_ctrl.sv
// Stopwatch control FSM driven by debounced Start/Stop and Reset buttons.
// Optional lap toggle output is built when SW_CTRL_LAP_EN is defined.
module sw_ctrl
   import sw_pkg::*;
#(
   parameter int DEBOUNCE_MS = DEBOUNCE_MS_DEF,
   parameter int CLEAR_MS    = CLEAR_MS_DEF
) (
   input  logic       Clock_1MSec,
   input  logic       Reset,
   input  logic       Btn_StartStop,
   input  logic       Btn_Reset,
   input  logic       Control,
`ifdef SW_CTRL_LAP_EN
   input  logic       Btn_Lap,
   output logic       Lap_S,
`endif
   output logic       Start_S,
   output logic       Stop_S,
   output logic       Reset_S,
   output logic [1:0] State_S
);

   sw_state_e            state, state_nxt;
   logic [CLR_CNT_W-1:0] clr_cnt, clr_nxt;
   logic                 ss_level, ss_press, ss_evt;
   logic                 rs_level, rs_press, rs_evt;

   sw_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_ss (
      .Clock_1MSec (Clock_1MSec),
      .Reset       (Reset),
      .raw         (Btn_StartStop),
      .level       (ss_level),
      .press       (ss_press)
   );

   sw_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_rs (
      .Clock_1MSec (Clock_1MSec),
      .Reset       (Reset),
      .raw         (Btn_Reset),
      .level       (rs_level),
      .press       (rs_press)
   );

   // A press is only honoured alongside the level it announces; Control=1 discards it.
   assign ss_evt = ss_press & ss_level & ~Control;
   assign rs_evt = rs_press & rs_level & ~Control;

   always_comb begin
      state_nxt = state;
      clr_nxt   = clr_cnt;
      if (!Control) begin
         case (state)
            IDLE:    if (ss_evt) state_nxt = RUN;
            RUN:     if (ss_evt) state_nxt = PAUSED;
            PAUSED: begin
               if (rs_evt) begin
                  state_nxt = CLEAR;
                  clr_nxt   = '0;
               end else if (ss_evt) begin
                  state_nxt = RUN;
               end
            end
            CLEAR: begin
               if (clr_cnt == CLR_CNT_W'(CLEAR_MS - 1)) state_nxt = IDLE;
               else                                      clr_nxt   = clr_cnt + 1'b1;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Outputs are registered from the next state so they track State_S cycle for cycle.
   always_ff @(posedge Clock_1MSec or negedge Reset) begin
      if (!Reset) begin
         state   <= IDLE;
         clr_cnt <= '0;
         Start_S <= 1'b0;
         Stop_S  <= 1'b0;
         Reset_S <= 1'b0;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_nxt;
         Start_S <= (state_nxt == RUN);
         Stop_S  <= (state_nxt == PAUSED);
         Reset_S <= (state_nxt == CLEAR);
      end
   end

   assign State_S = state;

`ifdef SW_CTRL_LAP_EN
   logic lap_level, lap_press;

   sw_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_db_lap (
      .Clock_1MSec (Clock_1MSec),
      .Reset       (Reset),
      .raw         (Btn_Lap),
      .level       (lap_level),
      .press       (lap_press)
   );

   always_ff @(posedge Clock_1MSec or negedge Reset) begin
      if (!Reset) begin
         Lap_S <= 1'b0;
      end else if (state_nxt == IDLE || state_nxt == CLEAR) begin
         Lap_S <= 1'b0;
      end else if (lap_press && lap_level && !Control &&
                   (state == RUN || state == PAUSED)) begin
         Lap_S <= ~Lap_S;
      end
   end
`endif

endmodule
